center_derivative: RTL and testbench
====================================

// Module: center_derivative
// PURPOSE
//  Streaming central-difference (discrete first-derivative) estimator.
//  For each accepted sample x[n], outputs y = x[n] - x[n-2] (optionally halved).
//  The result is the derivative centred on x[n-1].
//  Sits in a sample-processing pipeline between a sample source and downstream
//  edge/slope detection logic.
// PARAMETERS
//  Nbits  8  input sample width; unsigned; Nbits >= 2
//  HALF   0  1: output (x[n]-x[n-2])>>>1 (arithmetic, floor); 0: raw difference
// PORTS
//  clk             in   1        rising-edge clock, sole clock domain
//  rst             in   1        synchronous reset, active-high
//  in_valid        in   1        IN_center_der carries a new sample this cycle
//  IN_center_der   in   Nbits    unsigned input sample x[n]
//  out_valid       out  1        out_center_der updated with new result this cycle
//  out_center_der  out  Nbits+1  signed two's-complement derivative
// BEHAVIOUR
//  - Interface: one clock clk; reset rst is synchronous and active-high.
//  - Reset (rst=1 at posedge):
//    - history regs x1, x2 <= 0
//    - fill counter <= 0
//    - out_valid <= 0
//    - out_center_der <= 0
//    - rst has priority over in_valid.
//  - Sample accept: at posedge with in_valid=1 and rst=0:
//    - x2 <= x1, x1 <= IN_center_der
//    - fill counter saturates at 2.
//  - Result: computed in the same cycle from IN_center_der and x2 (old x2 = x[n-2]).
//    - Zero-extend both operands to Nbits+1, subtract: d = x[n] - x[n-2].
//    - Range -(2^Nbits-1)..+(2^Nbits-1); always fits Nbits+1 signed, no overflow.
//    - HALF=1: out = d >>> 1 (sign-preserving, rounds toward -inf).
//  - Latency: registered output, 1 cycle.
//    - out_valid and out_center_der update at the posedge that accepts x[n].
//  - Warm-up: out_valid=0 for the first 2 accepted samples after reset.
//    - out_center_der still holds 0 during warm-up.
//    - From the 3rd accepted sample on, out_valid=1 on every accepting cycle.
//  - Stall: in_valid=0 gives out_valid=0 next cycle.
//    - out_center_der, x1, x2 and the fill counter hold their values.
//    - Gaps do not break the sample sequence.
//  - Reset mid-stream discards history; warm-up restarts (2 more samples needed).
//  - No backpressure: downstream must accept every out_valid pulse.
//  - All outputs driven from flops; no combinational input-to-output path.
// TESTING (Nbits=2, HALF=0 unless noted)
//  1. Reset then samples 0,2,2,3 on consecutive cycles
//     -> out_valid 0,0,1,1; results +2 (3'b010), +1 (3'b001).
//  2. Samples 3,0,0 -> 3rd result -3 (3'b101); samples 0,1,3 -> +3 (3'b011).
//     Checks full-scale extremes with no overflow.
//  3. Samples 0,2 with idle gaps of 4 cycles, then 3 -> single out_valid pulse, value +3.
//     out_center_der held during the gaps.
//  4. Assert rst after 5 samples -> out_valid and out_center_der = 0 next cycle.
//     The next 2 samples give no out_valid; the 3rd does.
//  5. HALF=1, samples 3,0,0 -> -2 (3'b110, floor of -1.5).
//     Samples 0,0,3 -> +1 (3'b001).
//  6. Random stream, 1000 samples with random in_valid.
//     Compare against a reference model of x[n]-x[n-2] on accepted samples only.

Source files
------------

// File: rtl/center_derivative.sv
// Streaming central-difference estimator: y = x[n] - x[n-2] (optionally halved),
// registered with one cycle of latency and a two-sample warm-up after reset.
module center_derivative #(
    parameter int Nbits = 8,
    parameter bit HALF  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [Nbits-1:0]        IN_center_der,
    output logic                    out_valid,
    output logic signed [Nbits:0]   out_center_der
);

    logic [Nbits-1:0]      x1, x2;
    logic [1:0]            fill;
    logic signed [Nbits:0] diff;
    logic signed [Nbits:0] res;

    // Zero-extended operands keep the difference inside Nbits+1 signed bits.
    assign diff = $signed({1'b0, IN_center_der}) - $signed({1'b0, x2});
    assign res  = HALF ? (diff >>> 1) : diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            x1             <= '0;
            x2             <= '0;
            fill           <= '0;
            out_valid      <= 1'b0;
            out_center_der <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                x2 <= x1;
                x1 <= IN_center_der;
                if (fill != 2'd2)
                    fill <= fill + 2'd1;
                // Result only once x2 holds a real sample; output holds otherwise.
                if (fill == 2'd2) begin
                    out_valid      <= 1'b1;
                    out_center_der <= res;
                end
            end
        end
    end

endmodule

// File: tb/tb_center_derivative.sv
// Bench for center_derivative: directed table, HALF corner sequences and a
// random stream checked against a queue-based model of x[n]-x[n-2].
module tb_center_derivative;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] din = '0;

    logic              v_a, v_h, v_w;
    logic signed [2:0] y_a, y_h;
    logic signed [8:0] y_w;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    center_derivative #(.Nbits(2), .HALF(1'b0)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .IN_center_der(din[1:0]),
        .out_valid(v_a), .out_center_der(y_a));
    center_derivative #(.Nbits(2), .HALF(1'b1)) dut_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .IN_center_der(din[1:0]),
        .out_valid(v_h), .out_center_der(y_h));
    center_derivative #(.Nbits(8), .HALF(1'b1)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .IN_center_der(din),
        .out_valid(v_w), .out_center_der(y_w));

    // Reference model: recent accepted samples per stream, plus held outputs.
    int q2[$];
    int q8[$];
    bit ev2, ev8;
    int ey_a, ey_h, ey_w;

    function automatic int floor_half(input int d);
        return (d >= 0) ? d / 2 : -((1 - d) / 2);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input bit v, input int x);
        if (r) begin
            q2.delete(); q8.delete();
            ev2 = 0; ev8 = 0; ey_a = 0; ey_h = 0; ey_w = 0;
        end else if (v) begin
            q2.push_back(x % 4);
            q8.push_back(x);
            if (q2.size() > 3) void'(q2.pop_front());
            if (q8.size() > 3) void'(q8.pop_front());
            ev2 = (q2.size() == 3);
            ev8 = (q8.size() == 3);
            if (ev2) begin
                ey_a = q2[2] - q2[0];
                ey_h = floor_half(q2[2] - q2[0]);
            end
            if (ev8) ey_w = floor_half(q8[2] - q8[0]);
        end else begin
            ev2 = 0; ev8 = 0;
        end
    endtask

    // Drive one cycle, then check every DUT against the model after the edge.
    task automatic step(input bit r, input bit v, input int x);
        rst = r; in_valid = v; din = 8'(x);
        @(posedge clk);
        #1;
        model_update(r, v, x);
        chk("model_v_a", int'(v_a), int'(ev2));
        chk("model_y_a", int'(y_a), ey_a);
        chk("model_v_h", int'(v_h), int'(ev2));
        chk("model_y_h", int'(y_h), ey_h);
        chk("model_v_w", int'(v_w), int'(ev8));
        chk("model_y_w", int'(y_w), ey_w);
    endtask

    typedef struct {
        bit r;
        bit v;
        int x;
        bit ev;
        int ey;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit v, input int x,
                                input bit ev, input int ey);
        vec_t t;
        t.r = r; t.v = v; t.x = x; t.ev = ev; t.ey = ey;
        tbl.push_back(t);
    endfunction

    initial begin
        // Reset state, then samples 0,2,2,3
        add(1,0,0, 0, 0);
        add(0,1,0, 0, 0); add(0,1,2, 0, 0); add(0,1,2, 1, 2); add(0,1,3, 1, 1);
        // Full-scale extremes
        add(1,0,0, 0, 0);
        add(0,1,3, 0, 0); add(0,1,0, 0, 0); add(0,1,0, 1, -3);
        add(1,0,0, 0, 0);
        add(0,1,0, 0, 0); add(0,1,1, 0, 0); add(0,1,3, 1, 3);
        // Idle gaps between samples do not break the sequence
        add(1,0,0, 0, 0);
        add(0,1,0, 0, 0);
        for (int i = 0; i < 4; i++) add(0,0,1, 0, 0);
        add(0,1,2, 0, 0);
        for (int i = 0; i < 4; i++) add(0,0,0, 0, 0);
        add(0,1,3, 1, 3);
        for (int i = 0; i < 4; i++) add(0,0,2, 0, 3);
        // Reset mid-stream restarts warm-up
        add(1,0,0, 0, 0);
        add(0,1,1, 0, 0); add(0,1,2, 0, 0); add(0,1,3, 1, 2);
        add(0,1,0, 1, -2); add(0,1,1, 1, -2);
        add(1,1,3, 0, 0);
        add(0,1,2, 0, 0); add(0,1,3, 0, 0); add(0,1,1, 1, -1);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].r, tbl[i].v, tbl[i].x);
            chk($sformatf("tbl%0d_v", i), int'(v_a), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_y", i), int'(y_a), tbl[i].ey);
        end

        // HALF=1 corner cases
        step(1,0,0);
        step(0,1,3); step(0,1,0); step(0,1,0);
        chk("half_neg_v", int'(v_h), 1);
        chk("half_neg_y", int'(y_h), -2);
        step(1,0,0);
        step(0,1,0); step(0,1,0); step(0,1,3);
        chk("half_pos_v", int'(v_h), 1);
        chk("half_pos_y", int'(y_h), 1);

        // Random stream with random in_valid and rare resets
        step(1,0,0);
        for (int i = 0; i < 1000; i++) begin
            bit r;
            bit v;
            r = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 99) < 70);
            step(r, v, int'($urandom_range(0, 255)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
